// File: rtl/pipe_ctrl_unit_if.sv
`default_nettype none
// pipe_ctrl_unit_if: Decode-stage inputs, per-stage control outputs and debug port of pipe_ctrl_unit.
// Revision: 1.0
interface pipe_ctrl_unit_if #(
  parameter int ALUCTL_W  = 4,
  parameter int DBG_SEL_W = 2
);
  logic [5:0]           opD;
  logic [5:0]           funcD;
  logic                 equalD;
  logic                 stallE;
  logic                 flushE;
  logic                 flushM;
  logic                 branchD;
  logic                 bneD;
  logic                 jumpD;
  logic                 pcsrcD;
  logic                 md_stallD;
  logic                 alusrcE;
  logic                 regdstE;
  logic                 shiftE;
  logic [ALUCTL_W-1:0]  alucontrolE;
  logic                 mdstartE;
  logic                 md_busy;
  logic                 md_done;
  logic                 mem2regE;
  logic                 mem2regM;
  logic                 mem2regW;
  logic                 memwriteM;
  logic                 regwriteE;
  logic                 regwriteM;
  logic                 regwriteW;
  logic [DBG_SEL_W-1:0] dbg_sel;
  logic [31:0]          dbg_data;

  modport slave (
    input  opD, funcD, equalD, stallE, flushE, flushM, dbg_sel,
    output branchD, bneD, jumpD, pcsrcD, md_stallD, alusrcE, regdstE, shiftE,
           alucontrolE, mdstartE, md_busy, md_done, mem2regE, mem2regM, mem2regW,
           memwriteM, regwriteE, regwriteM, regwriteW, dbg_data
  );

  modport master (
    output opD, funcD, equalD, stallE, flushE, flushM, dbg_sel,
    input  branchD, bneD, jumpD, pcsrcD, md_stallD, alusrcE, regdstE, shiftE,
           alucontrolE, mdstartE, md_busy, md_done, mem2regE, mem2regM, mem2regW,
           memwriteM, regwriteE, regwriteM, regwriteW, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// pipe_ctrl_unit: 5-stage MIPS control unit with E/M/W control registers and a MULT/DIV busy sequencer.
// Revision: 1.0
module pipe_ctrl_unit #(
  parameter int ALUCTL_W  = 4,
  parameter int MD_LAT    = 8,
  parameter int DBG_SEL_W = 2
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pipe_ctrl_unit_if.slave bus
);
  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_bne  = 6'b000101;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_ori  = 6'b001101;
  localparam logic [5:0] c_op_slti = 6'b001010;
  localparam logic [5:0] c_op_j    = 6'b000010;

  localparam logic [3:0] c_alu_and = 4'd0;
  localparam logic [3:0] c_alu_or  = 4'd1;
  localparam logic [3:0] c_alu_add = 4'd2;
  localparam logic [3:0] c_alu_xor = 4'd3;
  localparam logic [3:0] c_alu_sll = 4'd4;
  localparam logic [3:0] c_alu_srl = 4'd5;
  localparam logic [3:0] c_alu_sub = 4'd6;
  localparam logic [3:0] c_alu_slt = 4'd7;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;
  localparam logic [7:0] c_md_cnt0 = 8'(MD_LAT - 1);

  logic       w_regwrite, w_mem2reg, w_memwrite, w_alusrc, w_regdst, w_shift;
  logic       w_branch, w_bne, w_jump, w_mdop, w_mf;
  logic [3:0] w_alu;

  always_comb begin
    w_regwrite = 1'b0; w_mem2reg = 1'b0; w_memwrite = 1'b0; w_alusrc = 1'b0;
    w_regdst   = 1'b0; w_shift   = 1'b0; w_branch   = 1'b0; w_bne    = 1'b0;
    w_jump     = 1'b0; w_mdop    = 1'b0; w_mf       = 1'b0; w_alu    = c_alu_and;
    case (bus.opD)
      c_op_r: begin
        case (bus.funcD)
          6'b100000: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_add; end
          6'b100010: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_sub; end
          6'b100100: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_and; end
          6'b100101: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_or;  end
          6'b100110: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_xor; end
          6'b101010: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_slt; end
          6'b000000: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_shift = 1'b1; w_alu = c_alu_sll; end
          6'b000010: begin w_regwrite = 1'b1; w_regdst = 1'b1; w_shift = 1'b1; w_alu = c_alu_srl; end
          6'b011000, 6'b011010: w_mdop = 1'b1;
          6'b010000, 6'b010010: begin
            w_mf = 1'b1; w_regwrite = 1'b1; w_regdst = 1'b1; w_alu = c_alu_add;
          end
          default: ;
        endcase
      end
      c_op_lw:   begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_mem2reg = 1'b1; w_alu = c_alu_add; end
      c_op_sw:   begin w_memwrite = 1'b1; w_alusrc = 1'b1; w_alu = c_alu_add; end
      c_op_beq:  begin w_branch = 1'b1; w_alu = c_alu_sub; end
      c_op_bne:  begin w_branch = 1'b1; w_bne = 1'b1; w_alu = c_alu_sub; end
      c_op_addi: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alu = c_alu_add; end
      c_op_ori:  begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alu = c_alu_or;  end
      c_op_slti: begin w_regwrite = 1'b1; w_alusrc = 1'b1; w_alu = c_alu_slt; end
      c_op_j:    w_jump = 1'b1;
      default: ;
    endcase
  end

  logic       regwriteE_q, mem2regE_q, memwriteE_q, alusrcE_q, regdstE_q, shiftE_q, mdopE_q;
  logic [3:0] alucontrolE_q;
  logic       regwriteM_q, mem2regM_q, memwriteM_q, regwriteW_q, mem2regW_q;

  // flushE takes priority over stallE so a held instruction can still be squashed
  always_ff @(posedge clk) begin
    if (reset || bus.flushE) begin
      regwriteE_q <= 1'b0; mem2regE_q <= 1'b0; memwriteE_q <= 1'b0; alusrcE_q <= 1'b0;
      regdstE_q   <= 1'b0; shiftE_q   <= 1'b0; mdopE_q     <= 1'b0; alucontrolE_q <= 4'd0;
    end else if (!bus.stallE) begin
      regwriteE_q <= w_regwrite; mem2regE_q <= w_mem2reg; memwriteE_q <= w_memwrite;
      alusrcE_q   <= w_alusrc;   regdstE_q  <= w_regdst;  shiftE_q    <= w_shift;
      mdopE_q     <= w_mdop;     alucontrolE_q <= w_alu;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flushM) begin
      regwriteM_q <= 1'b0; mem2regM_q <= 1'b0; memwriteM_q <= 1'b0;
    end else begin
      regwriteM_q <= regwriteE_q; mem2regM_q <= mem2regE_q; memwriteM_q <= memwriteE_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwriteW_q <= 1'b0; mem2regW_q <= 1'b0;
    end else begin
      regwriteW_q <= regwriteM_q; mem2regW_q <= mem2regM_q;
    end
  end

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       w_md_launch, w_mdstart, w_md_busy, w_md_done;

  assign w_md_launch = mdopE_q & ~bus.stallE & ~bus.flushE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_idle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      c_idle: if (w_md_launch) begin state_d = c_busy; cnt_d = c_md_cnt0; end
      c_busy: if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1; else state_d = c_done;
      c_done: state_d = c_idle;
      default: begin state_d = c_idle; cnt_d = 8'd0; end
    endcase
  end

  always_comb begin
    w_mdstart = (state_q == c_idle) & w_md_launch;
    w_md_busy = (state_q == c_busy);
    w_md_done = (state_q == c_done);
  end

  logic [7:0]  w_flags;
  logic [31:0] w_dbg;

  // each debug flag occupies the LSB of its own nibble for easy reading on a hex display
  always_comb begin
    w_flags = {mem2regE_q, mem2regM_q, mem2regW_q, w_branch,
               regwriteE_q, regwriteM_q, regwriteW_q, regdstE_q};
    w_dbg   = 32'd0;
    case (32'(bus.dbg_sel))
      32'd0: for (int i = 0; i < 8; i++) w_dbg[4*i] = w_flags[i];
      32'd1: for (int i = 0; i < 6; i++) w_dbg[4*i] = bus.opD[i];
      32'd2: for (int i = 0; i < 6; i++) w_dbg[4*i] = bus.funcD[i];
      32'd3: w_dbg = {6'd0, state_q, cnt_q, 8'h00, 4'h0, alucontrolE_q};
      default: ;
    endcase
  end

  assign bus.branchD     = w_branch;
  assign bus.bneD        = w_bne;
  assign bus.jumpD       = w_jump;
  assign bus.pcsrcD      = w_branch & (bus.equalD ^ w_bne);
  assign bus.md_stallD   = (w_mdop | w_mf) & (state_q != c_idle);
  assign bus.alusrcE     = alusrcE_q;
  assign bus.regdstE     = regdstE_q;
  assign bus.shiftE      = shiftE_q;
  assign bus.alucontrolE = ALUCTL_W'(alucontrolE_q);
  assign bus.mdstartE    = w_mdstart;
  assign bus.md_busy     = w_md_busy;
  assign bus.md_done     = w_md_done;
  assign bus.mem2regE    = mem2regE_q;
  assign bus.mem2regM    = mem2regM_q;
  assign bus.mem2regW    = mem2regW_q;
  assign bus.memwriteM   = memwriteM_q;
  assign bus.regwriteE   = regwriteE_q;
  assign bus.regwriteM   = regwriteM_q;
  assign bus.regwriteW   = regwriteW_q;
  assign bus.dbg_data    = w_dbg;
endmodule
`default_nettype wire
